cfu_table_controller: RTL and testbench

- Sequences and shares one 32x16 custom-function LUT RAM between two requesters.
  - Lookup port: the datapath read stream.
  - Config port: host/boot-time writes and bulk fills.
- Drives the RAM's single shared address, write-enable and write-data pins; the RAM has asynchronous read.
- Registers the lookup result, runs an optional table-initialisation sweep after reset, and bounds starvation of config writes.

---
 rtl/cfu_table_controller.sv | 129 ++++++++++++
 tb/tb_cfu_table_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_table_controller.sv
// Arbiter and sequencer for a 32x16 custom-function LUT RAM shared by a
// lookup stream and a config port, with reset-time and bulk fill sweeps.
module cfu_table_controller #(
  parameter int unsigned INIT_ON_RESET = 1,
  parameter logic [15:0] INIT_VALUE    = 16'h0000,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        lookup_valid,
  output logic        lookup_ready,
  input  logic [4:0]  lookup_addr,
  output logic [15:0] lookup_rdata,
  output logic        lookup_rvalid,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_fill,
  input  logic [4:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        busy,
  output logic        ram_we,
  output logic [4:0]  ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FILL
  } state_t;

  localparam state_t     RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [7:0] STARVE_THR  = 8'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [4:0]  sweep_ptr, sweep_nxt;
  logic [7:0]  starve_cnt, starve_nxt;
  logic [15:0] fill_data, fill_nxt;
  logic        lookup_fire;
  logic        cfg_fire;
  logic        starved;

  assign starved = (starve_cnt >= STARVE_THR);
  assign busy    = (state != ST_RUN);

  always_comb begin
    state_nxt    = state;
    sweep_nxt    = sweep_ptr;
    starve_nxt   = starve_cnt;
    fill_nxt     = fill_data;
    lookup_ready = 1'b0;
    cfg_ready    = 1'b0;
    lookup_fire  = 1'b0;
    cfg_fire     = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = lookup_addr;
    ram_din      = cfg_data;

    unique case (state)
      ST_INIT, ST_FILL: begin
        ram_we    = 1'b1;
        ram_addr  = sweep_ptr;
        ram_din   = (state == ST_INIT) ? INIT_VALUE : fill_data;
        sweep_nxt = sweep_ptr + 5'd1;
        if (sweep_ptr == 5'd31) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A starved config write takes the port outright for one cycle.
        if (starved) begin
          cfg_ready = 1'b1;
        end else begin
          lookup_ready = 1'b1;
          cfg_ready    = !lookup_valid;
        end
        lookup_fire = lookup_valid && lookup_ready;
        cfg_fire    = cfg_valid && cfg_ready;
        if (cfg_fire) begin
          starve_nxt = '0;
          if (cfg_fill) begin
            fill_nxt  = cfg_data;
            state_nxt = ST_FILL;
          end else begin
            ram_we   = 1'b1;
            ram_addr = cfg_addr;
            ram_din  = cfg_data;
          end
        end else if (cfg_valid && (starve_cnt != 8'hff)) begin
          starve_nxt = starve_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase

    // Handshakes and writes are suppressed while reset is held, whatever the state.
    if (!reset_n) begin
      lookup_ready = 1'b0;
      cfg_ready    = 1'b0;
      lookup_fire  = 1'b0;
      cfg_fire     = 1'b0;
      ram_we       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_STATE;
      sweep_ptr     <= '0;
      starve_cnt    <= '0;
      fill_data     <= '0;
      lookup_rdata  <= '0;
      lookup_rvalid <= 1'b0;
    end else begin
      state         <= state_nxt;
      sweep_ptr     <= sweep_nxt;
      starve_cnt    <= starve_nxt;
      fill_data     <= fill_nxt;
      lookup_rvalid <= lookup_fire;
      if (lookup_fire) begin
        lookup_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_cfu_table_controller.sv
// Directed bench for cfu_table_controller: vector table for RUN arbitration
// plus hand sequences for sweeps, starvation, fill, streaming and reset.
module tb_cfu_table_controller;

  logic        clock;
  logic        reset_n;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [4:0]  lookup_addr;
  logic [15:0] lookup_rdata;
  logic        lookup_rvalid;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_fill;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        busy;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int checks = 0;
  int errors = 0;

  cfu_table_controller #(
    .INIT_ON_RESET(1),
    .INIT_VALUE   (16'h5a5a),
    .STARVE_LIMIT (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_valid (lookup_valid),
    .lookup_ready (lookup_ready),
    .lookup_addr  (lookup_addr),
    .lookup_rdata (lookup_rdata),
    .lookup_rvalid(lookup_rvalid),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_fill     (cfg_fill),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .busy         (busy),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Behavioural RAM: synchronous write, asynchronous read.
  logic [15:0] mem [32];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        lv;
    logic [4:0]  la;
    logic        cv;
    logic        cf;
    logic [4:0]  ca;
    logic [15:0] cd;
    logic        e_lr;
    logic        e_cr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic        e_rv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] la, input logic cv,
                       input logic cf, input logic [4:0] ca, input logic [15:0] cd);
    lookup_valid = lv;
    lookup_addr  = la;
    cfg_valid    = cv;
    cfg_fill     = cf;
    cfg_addr     = ca;
    cfg_data     = cd;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy",   16'(busy), 16'd1);
    chk("rst_we",     16'(ram_we), 16'd0);
    chk("rst_lready", 16'(lookup_ready), 16'd0);
    chk("rst_cready", 16'(cfg_ready), 16'd0);
    chk("rst_rvalid", 16'(lookup_rvalid), 16'd0);
    chk("rst_rdata",  lookup_rdata, 16'h0000);
  endtask

  task automatic check_sweep(input logic [15:0] val);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("sw_busy",   16'(busy), 16'd1);
      chk("sw_we",     16'(ram_we), 16'd1);
      chk("sw_addr",   16'(ram_addr), 16'(i));
      chk("sw_din",    ram_din, val);
      chk("sw_lready", 16'(lookup_ready), 16'd0);
      chk("sw_cready", 16'(cfg_ready), 16'd0);
      step();
    end
    chk("sw_done_busy", 16'(busy), 16'd0);
  endtask

  task automatic lookup(input logic [4:0] a, input logic [15:0] exp, input string name);
    drive(1'b1, a, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk({name, "_ready"}, 16'(lookup_ready), 16'd1);
    step();
    chk({name, "_rvalid"}, 16'(lookup_rvalid), 16'd1);
    chk({name, "_rdata"}, lookup_rdata, exp);
    drive(1'b0, a, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 16'h5a5a};
    vecs[1] = '{1'b0, 5'd7, 1'b1, 1'b0, 5'd3, 16'hcaca, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 16'h5a5a};
    vecs[2] = '{1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 16'hcaca};
    vecs[3] = '{1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 16'h1111, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 16'hcaca};
    vecs[4] = '{1'b0, 5'd3, 1'b1, 1'b0, 5'd4, 16'h1111, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 16'hcaca};
    vecs[5] = '{1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 16'h1111};
    vecs[6] = '{1'b0, 5'd9, 1'b0, 1'b0, 5'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 16'h1111};
    vecs[7] = '{1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 16'h5a5a};

    reset_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    check_reset_outputs();
    step();
    reset_n = 1'b1;

    // Power-up sweep, then the initial value is readable.
    check_sweep(16'h5a5a);

    // RUN arbitration vectors.
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].lv, vecs[v].la, vecs[v].cv, vecs[v].cf, vecs[v].ca, vecs[v].cd);
      #1;
      chk($sformatf("v%0d_lready", v), 16'(lookup_ready), 16'(vecs[v].e_lr));
      chk($sformatf("v%0d_cready", v), 16'(cfg_ready), 16'(vecs[v].e_cr));
      chk($sformatf("v%0d_we", v), 16'(ram_we), 16'(vecs[v].e_we));
      chk($sformatf("v%0d_addr", v), 16'(ram_addr), 16'(vecs[v].e_addr));
      step();
      chk($sformatf("v%0d_rvalid", v), 16'(lookup_rvalid), 16'(vecs[v].e_rv));
      chk($sformatf("v%0d_rdata", v), lookup_rdata, vecs[v].e_rd);
    end

    // Starvation: 8 refusals, then the config write preempts a lookup.
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd10, 16'hbeef);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("st_cready_low", 16'(cfg_ready), 16'd0);
      chk("st_lready_high", 16'(lookup_ready), 16'd1);
      chk("st_we_low", 16'(ram_we), 16'd0);
      step();
    end
    #1;
    chk("st_cready_win", 16'(cfg_ready), 16'd1);
    chk("st_lready_block", 16'(lookup_ready), 16'd0);
    chk("st_we_win", 16'(ram_we), 16'd1);
    chk("st_addr_win", 16'(ram_addr), 16'd10);
    step();
    chk("st_no_rvalid", 16'(lookup_rvalid), 16'd0);
    drive(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("st_resume_ready", 16'(lookup_ready), 16'd1);
    step();
    chk("st_resume_rvalid", 16'(lookup_rvalid), 16'd1);
    chk("st_resume_rdata", lookup_rdata, 16'hbeef);

    // Bulk fill.
    drive(1'b0, 5'd0, 1'b1, 1'b1, 5'd17, 16'hacac);
    #1;
    chk("fill_acc_cready", 16'(cfg_ready), 16'd1);
    chk("fill_acc_we", 16'(ram_we), 16'd0);
    chk("fill_acc_busy", 16'(busy), 16'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 16'h0);
    check_sweep(16'hacac);
    lookup(5'd0, 16'hacac, "fill_lk0");
    lookup(5'd31, 16'hacac, "fill_lk31");

    // Distinct contents, then a back-to-back 32-entry stream.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 1'b1, 1'b0, 5'(i), 16'h1000 + 16'(i) * 16'h0101);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, 1'b0, 5'd0, 16'h0);
      step();
      chk($sformatf("str%0d_rvalid", i), 16'(lookup_rvalid), 16'd1);
      chk($sformatf("str%0d_rdata", i), lookup_rdata, 16'h1000 + 16'(i) * 16'h0101);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    chk("str_end_rvalid", 16'(lookup_rvalid), 16'd0);

    // Reset abandons a sweep part-way; the next sweep starts over at 0.
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    #1;
    chk("mid_addr12", 16'(ram_addr), 16'd12);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    step();
    step();
    reset_n = 1'b1;
    check_sweep(16'h5a5a);
    lookup(5'd7, 16'h5a5a, "post_lk7");
    lookup(5'd20, 16'h5a5a, "post_lk20");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
